// File: rtl/fdiv_pkg.sv
// Shared widths, limits and FSM encodings for the 10-bit {M,E} float datapath.
// The multiplier imports the same package.
package fdiv_pkg;

  localparam int unsigned MW = 6;        // mantissa width, sign included
  localparam int unsigned EW = 4;        // exponent width
  localparam int unsigned QB = MW - 1;   // quotient bits, one per DIV cycle
  localparam int unsigned FW = MW + EW;  // packed word width
  localparam int unsigned XW = EW + 2;   // working exponent width, wide enough to never wrap
  localparam int unsigned RW = MW + 2;   // partial remainder width
  localparam int unsigned CW = $clog2(QB + 1);

  localparam logic signed [XW-1:0] EXP_MAX = 6'sd7;
  localparam logic signed [XW-1:0] EXP_MIN = -6'sd8;
  localparam logic [FW-1:0]        FP_ZERO = 10'b000000_1000;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StPrep = 2'd1;
  localparam logic [1:0] StDiv  = 2'd2;
  localparam logic [1:0] StPack = 2'd3;

  // Mantissa split into sign and unsigned Q1.6 magnitude.
  typedef struct packed {
    logic          sign;
    logic [MW:0]   mag;
    logic          zero;
  } unpacked_t;

endpackage

// File: rtl/fp10_unpack.sv
// Splits a two's-complement fraction mantissa into sign, Q1.6 magnitude and zero flag.
module fp10_unpack
  import fdiv_pkg::*;
(
  input  logic [MW-1:0] m_i,
  output unpacked_t     u_o
);

  logic [MW-1:0] abs_m;

  always_comb begin
    // -1.0 negates to 2^(MW-1), which is still correct when read as unsigned
    abs_m    = m_i[MW-1] ? -m_i : m_i;
    u_o.sign = m_i[MW-1];
    u_o.mag  = {abs_m, 1'b0};
    u_o.zero = (m_i == '0);
  end

endmodule

// File: rtl/fdiv.sv
// Sequential restoring divider for the 10-bit {M,E} float format (F = A / B).
// Load/start/done handshake shared with the multiplier.
module fdiv
  import fdiv_pkg::*;
(
  input  logic          clk,
  input  logic          rstn,
  input  logic          load,
  input  logic          start,
  input  logic [FW-1:0] A,
  input  logic [FW-1:0] B,
  output logic [FW-1:0] F,
  output logic          done,
  output logic          busy,
  output logic          ovf,
  output logic          udf,
  output logic          dbz
);

  logic [1:0]           state_q, state_d;
  logic [FW-1:0]        a_q, a_d, b_q, b_d;
  logic                 sq_q, sq_d;
  logic signed [XW-1:0] e_q, e_d;
  logic [RW-1:0]        rem_q, rem_d;
  logic [QB-1:0]        q_q, q_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [FW-1:0]        f_q, f_d;
  logic                 done_q, done_d;
  logic                 ovf_q, ovf_d, udf_q, udf_d, dbz_q, dbz_d;

  unpacked_t            ua, ub;
  logic signed [XW-1:0] ea_x, eb_x, e_prep;
  logic                 a_ge_b;
  logic [RW-1:0]        rem_sh, rem_sub;
  logic                 bit_ok;
  logic [MW-1:0]        mq;
  logic                 busy_w;

  fp10_unpack u_unpack_a (
    .m_i (a_q[FW-1:EW]),
    .u_o (ua)
  );

  fp10_unpack u_unpack_b (
    .m_i (b_q[FW-1:EW]),
    .u_o (ub)
  );

  assign busy_w = (state_q != StIdle) || done_q;

  always_comb begin
    ea_x    = {{(XW-EW){a_q[EW-1]}}, a_q[EW-1:0]};
    eb_x    = {{(XW-EW){b_q[EW-1]}}, b_q[EW-1:0]};
    a_ge_b  = (ua.mag >= ub.mag);
    // Pre-shifting the dividend keeps the quotient in [0.5,1): no post-normalisation needed
    e_prep  = ea_x - eb_x + XW'(a_ge_b);
    rem_sh  = rem_q << 1;
    rem_sub = rem_sh - {1'b0, ub.mag};
    bit_ok  = (rem_sh >= {1'b0, ub.mag});
    mq      = sq_q ? -{1'b0, q_q} : {1'b0, q_q};
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sq_d    = sq_q;
    e_d     = e_q;
    rem_d   = rem_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    f_d     = f_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    dbz_d   = dbz_q;

    if (load && !busy_w) begin
      a_d = A;
      b_d = B;
    end

    case (state_q)
      StIdle: begin
        if (start && !load && !done_q) begin
          state_d = StPrep;
        end
      end
      StPrep: begin
        sq_d    = ua.sign ^ ub.sign;
        e_d     = e_prep;
        rem_d   = a_ge_b ? {1'b0, ua.mag >> 1} : {1'b0, ua.mag};
        q_d     = '0;
        cnt_d   = '0;
        state_d = (ua.zero || ub.zero) ? StPack : StDiv;
      end
      StDiv: begin
        q_d   = {q_q[QB-2:0], bit_ok};
        rem_d = bit_ok ? rem_sub : rem_sh;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(QB - 1)) begin
          state_d = StPack;
        end
      end
      StPack: begin
        state_d = StIdle;
        done_d  = 1'b1;
        f_d     = FP_ZERO;
        ovf_d   = 1'b0;
        udf_d   = 1'b0;
        dbz_d   = 1'b0;
        if (ub.zero) begin
          dbz_d = 1'b1;
        end else if (ua.zero) begin
          f_d = FP_ZERO;
        end else if (e_q > EXP_MAX) begin
          ovf_d = 1'b1;
          f_d   = {mq, EXP_MAX[EW-1:0]};
        end else if (e_q < EXP_MIN) begin
          udf_d = 1'b1;
        end else begin
          f_d = {mq, e_q[EW-1:0]};
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sq_q    <= 1'b0;
      e_q     <= '0;
      rem_q   <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      f_q     <= FP_ZERO;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sq_q    <= sq_d;
      e_q     <= e_d;
      rem_q   <= rem_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      f_q     <= f_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
      dbz_q   <= dbz_d;
    end
  end

  assign F    = f_q;
  assign done = done_q;
  assign busy = busy_w;
  assign ovf  = ovf_q;
  assign udf  = udf_q;
  assign dbz  = dbz_q;

endmodule

// File: tb/tb_fdiv.sv
// Scoreboard bench for fdiv: stimulus pushes model results, a monitor pops on each done.
module tb_fdiv;

  logic       clk = 1'b0;
  logic       rstn, load, start;
  logic [9:0] A, B, F;
  logic       done, busy, ovf, udf, dbz;

  fdiv dut (
    .clk   (clk),
    .rstn  (rstn),
    .load  (load),
    .start (start),
    .A     (A),
    .B     (B),
    .F     (F),
    .done  (done),
    .busy  (busy),
    .ovf   (ovf),
    .udf   (udf),
    .dbz   (dbz)
  );

  typedef struct {
    logic [9:0] f;
    logic       ovf;
    logic       udf;
    logic       dbz;
    int         lat;
    int         start_cyc;
    string      tag;
  } exp_t;

  exp_t sbq[$];
  exp_t mx;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  // Reference: quotient value computed directly as a truncated ratio of the fractions.
  function automatic exp_t model(input logic [9:0] a, input logic [9:0] b);
    exp_t x;
    int ma, mb, ea, eb, ia, ib, q, e, m;
    logic [5:0] m6;
    logic [3:0] e4;
    ma = int'($signed(a[9:4]));
    mb = int'($signed(b[9:4]));
    ea = int'($signed(a[3:0]));
    eb = int'($signed(b[3:0]));
    x.f = 10'b000000_1000;
    x.ovf = 1'b0;
    x.udf = 1'b0;
    x.dbz = 1'b0;
    x.lat = 7;
    x.start_cyc = 0;
    x.tag = "";
    if (mb == 0) begin
      x.dbz = 1'b1;
      x.lat = 2;
    end else if (ma == 0) begin
      x.lat = 2;
    end else begin
      ia = (ma < 0) ? -ma : ma;
      ib = (mb < 0) ? -mb : mb;
      // ratio ia/ib scaled so the 5-bit quotient lies in [0.5,1)
      if (ia >= ib) begin
        e = ea - eb + 1;
        q = (ia * 16) / ib;
      end else begin
        e = ea - eb;
        q = (ia * 32) / ib;
      end
      m  = ((ma < 0) != (mb < 0)) ? -q : q;
      m6 = m[5:0];
      if (e > 7) begin
        x.ovf = 1'b1;
        x.f   = {m6, 4'b0111};
      end else if (e < -8) begin
        x.udf = 1'b1;
      end else begin
        e4  = e[3:0];
        x.f = {m6, e4};
      end
    end
    return x;
  endfunction

  always @(negedge clk) begin
    if (rstn && done) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: got done with F=%h, want no done", F);
      end else begin
        mx = sbq.pop_front();
        chk({mx.tag, "_F"},   int'(F),   int'(mx.f));
        chk({mx.tag, "_ovf"}, int'(ovf), int'(mx.ovf));
        chk({mx.tag, "_udf"}, int'(udf), int'(mx.udf));
        chk({mx.tag, "_dbz"}, int'(dbz), int'(mx.dbz));
        chk({mx.tag, "_lat"}, cyc - mx.start_cyc, mx.lat);
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      n_cmp++;
      n_err++;
      $display("FAIL idle_timeout: busy got 1 after %0d cycles, want 0", n);
    end
  endtask

  task automatic push_exp(input logic [9:0] a, input logic [9:0] b, input string tag);
    exp_t x;
    x = model(a, b);
    x.start_cyc = cyc + 1;
    x.tag = tag;
    sbq.push_back(x);
  endtask

  task automatic run_op(input logic [9:0] a, input logic [9:0] b, input string tag);
    wait_idle();
    A = a;
    B = b;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    start = 1'b1;
    push_exp(a, b, tag);
    @(negedge clk);
    start = 1'b0;
  endtask

  function automatic logic [5:0] rand_mant();
    int v;
    if ($urandom_range(0, 9) == 0) return 6'd0;
    v = int'($urandom_range(16, 31));
    if ($urandom_range(0, 1) == 1) v = -v - 1;
    return v[5:0];
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_F"},    int'(F),    int'(10'b000000_1000));
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_ovf"},  int'(ovf),  0);
    chk({tag, "_udf"},  int'(udf),  0);
    chk({tag, "_dbz"},  int'(dbz),  0);
  endtask

  initial begin
    logic [9:0] ra, rb;
    rstn  = 1'b0;
    load  = 1'b0;
    start = 1'b0;
    A     = '0;
    B     = '0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rstn = 1'b1;
    @(negedge clk);

    run_op(10'b010000_0000, 10'b010000_0000, "one");
    run_op(10'b010000_0000, 10'b011000_0000, "frac");
    run_op(10'b110000_0010, 10'b010000_0001, "neg");
    run_op(10'b010000_0111, 10'b010000_1000, "ovf");
    run_op(10'b010000_1000, 10'b011000_0001, "udf");
    run_op(10'b010000_0000, 10'b000000_0011, "dbz");
    run_op(10'b000000_0011, 10'b010000_0000, "zero");
    run_op(10'b100000_0000, 10'b100000_0000, "m1_m1");

    // Load and start together: load wins, start ignored
    wait_idle();
    A = 10'b011000_0001;
    B = 10'b101000_0011;
    load  = 1'b1;
    start = 1'b1;
    @(negedge clk);
    load  = 1'b0;
    start = 1'b0;
    chk("ldst_busy", int'(busy), 0);
    @(negedge clk);
    start = 1'b1;
    push_exp(10'b011000_0001, 10'b101000_0011, "ldst");
    @(negedge clk);
    start = 1'b0;

    // Start and operand change during DIV are ignored
    run_op(10'b010000_0000, 10'b011000_0000, "busy_start");
    @(negedge clk);
    chk("busy_mid", int'(busy), 1);
    start = 1'b1;
    load  = 1'b1;
    A     = 10'b011111_0011;
    B     = 10'b010000_0101;
    @(negedge clk);
    start = 1'b0;
    load  = 1'b0;
    wait_idle();
    start = 1'b1;
    push_exp(10'b010000_0000, 10'b011000_0000, "relatch");
    @(negedge clk);
    start = 1'b0;

    // Abort mid-DIV after an overflow result so the flags are non-zero
    run_op(10'b010000_0111, 10'b010000_1000, "pre_abort");
    wait_idle();
    A = 10'b011000_0000;
    B = 10'b010000_0000;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk_reset_outputs("abort");
    @(negedge clk);
    rstn = 1'b1;
    repeat (10) @(negedge clk);
    chk("abort_idle", int'(busy), 0);
    run_op(10'b101000_0001, 10'b011000_1111, "post_abort");

    for (int i = 0; i < 60; i++) begin
      ra = {rand_mant(), 4'($urandom_range(0, 15))};
      rb = {rand_mant(), 4'($urandom_range(0, 15))};
      run_op(ra, rb, "rand");
    end

    wait_idle();
    repeat (3) @(negedge clk);
    chk("sb_drain", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
